exec_stage: RTL and testbench

- Execute stage of the 16-bit CPU, directly upstream of the 8x16 register file.
- Accepts an operation, destination index and the two source operand values (rs1/rs2 reads from the register file).
- Computes the result with single-cycle logic or an iterative shift-add multiplier.
- Presents a registered writeback (rd, data, write enable) to the register file under a valid/ready handshake.

---
 rtl/exec_stage.sv | 191 +++++++++++++++++++
 tb/tb_exec_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier, feeding a
// registered writeback bundle. Define EXEC_DIV_EN to add an iterative unsigned restoring divider on op 111.
module exec_stage #(
  parameter int WIDTH = 16,
  parameter int RIDX  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [RIDX-1:0]  rd_in,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_we,
  output logic [RIDX-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_z,
  output logic             flag_c,
  output logic             illegal_op,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_data;
  logic             alu_c;
  logic             alu_ill;
  logic [WIDTH-1:0] mul_next;

  assign in_ready = !reset && ((state == S_IDLE) || (state == S_DONE && wb_ready));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  assign sum  = {1'b0, rs1_val} + {1'b0, rs2_val};
  assign diff = {1'b0, rs1_val} - {1'b0, rs2_val};

  always_comb begin
    alu_data = '0;
    alu_c    = 1'b0;
    alu_ill  = 1'b0;
    case (op)
      OP_ADD: begin alu_data = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      OP_SUB: begin alu_data = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      OP_AND: alu_data = rs1_val & rs2_val;
      OP_OR:  alu_data = rs1_val | rs2_val;
      OP_XOR: alu_data = rs1_val ^ rs2_val;
      OP_SHL: alu_data = rs1_val << rs2_val[3:0];
`ifndef EXEC_DIV_EN
      OP_DIV: alu_ill = 1'b1;
`endif
      default: alu_data = '0;
    endcase
  end

  // Only the low WIDTH bits of the product are kept, so bits shifted out of mcand never matter.
  assign mul_next = acc + (mplier[0] ? mcand : '0);

`ifdef EXEC_DIV_EN
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  // mplier holds the dividend, shifting quotient bits in from the right; a zero divisor yields all ones.
  assign rem_sh   = {rem, mplier[WIDTH-1]};
  assign div_ge   = (rem_sh >= {1'b0, mcand});
  assign rem_next = div_ge ? WIDTH'(rem_sh - {1'b0, mcand}) : rem_sh[WIDTH-1:0];
  assign q_next   = {mplier[WIDTH-2:0], div_ge};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      illegal_op <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
`ifdef EXEC_DIV_EN
      rem        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            wb_rd <= rd_in;
            cnt   <= '0;
            if (op == OP_MUL) begin
              state    <= S_MUL;
              wb_valid <= 1'b0;
              wb_we    <= 1'b0;
              mcand    <= rs1_val;
              mplier   <= rs2_val;
              acc      <= '0;
`ifdef EXEC_DIV_EN
            end else if (op == OP_DIV) begin
              state    <= S_DIV;
              wb_valid <= 1'b0;
              wb_we    <= 1'b0;
              mcand    <= rs2_val;
              mplier   <= rs1_val;
              rem      <= '0;
`endif
            end else begin
              state      <= S_DONE;
              wb_valid   <= 1'b1;
              wb_we      <= !alu_ill;
              wb_data    <= alu_data;
              flag_z     <= (alu_data == '0);
              flag_c     <= alu_c;
              illegal_op <= alu_ill;
            end
          end else if (state == S_IDLE || wb_ready) begin
            state    <= S_IDLE;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end
        end
        S_MUL: begin
          acc    <= mul_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state      <= S_DONE;
            wb_valid   <= 1'b1;
            wb_we      <= 1'b1;
            wb_data    <= mul_next;
            flag_z     <= (mul_next == '0);
            flag_c     <= 1'b0;
            illegal_op <= 1'b0;
          end
        end
`ifdef EXEC_DIV_EN
        S_DIV: begin
          rem    <= rem_next;
          mplier <= q_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state      <= S_DONE;
            wb_valid   <= 1'b1;
            wb_we      <= 1'b1;
            wb_data    <= q_next;
            flag_z     <= (q_next == '0);
            flag_c     <= 1'b0;
            illegal_op <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed vectors plus a per-handshake compare
// against an arithmetic reference model of each op.
module tb_exec_stage;
  localparam int W = 16;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [R-1:0] rd_in;
  logic [W-1:0] rs1_val;
  logic [W-1:0] rs2_val;
  logic         wb_valid;
  logic         wb_ready;
  logic         wb_we;
  logic [R-1:0] wb_rd;
  logic [W-1:0] wb_data;
  logic         flag_z;
  logic         flag_c;
  logic         illegal_op;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         we;
    logic         z;
    logic         c;
    logic         ill;
    logic [R-1:0] rd;
  } exp_t;

  exp_t exp_q[$];

  exec_stage #(.WIDTH(W), .RIDX(R)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rd_in(rd_in), .rs1_val(rs1_val), .rs2_val(rs2_val), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c), .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [R-1:0] r,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int unsigned p;
    e.rd  = r;
    e.we  = 1'b1;
    e.c   = 1'b0;
    e.ill = 1'b0;
    e.data = '0;
    case (o)
      3'd0: begin p = int'(a) + int'(b); e.data = p[15:0]; e.c = p[16]; end
      3'd1: begin e.data = a - b; e.c = (a < b); end
      3'd2: e.data = a & b;
      3'd3: e.data = a | b;
      3'd4: e.data = a ^ b;
      3'd5: e.data = a << b[3:0];
      3'd6: begin p = int'(a) * int'(b); e.data = p[15:0]; end
      default: begin
`ifdef EXEC_DIV_EN
        e.data = (b == 0) ? 16'hFFFF : a / b;
`else
        e.we = 1'b0; e.ill = 1'b1; e.data = '0;
`endif
      end
    endcase
    e.z = (e.data == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_wb: got wb_valid=1 rd=%0d data=%h, want no pending op", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_bundle", {wb_data, wb_we, flag_z, flag_c, illegal_op, wb_rd}, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present an op and hold it until the stage takes it; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [R-1:0] r,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; op = o; rd_in = r; rs1_val = a; rs2_val = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      #2;
      ok = in_ready;
      if (ok) exp_q.push_back(model(o, r, a, b));
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0 for 100 cycles, want accept op=%0d", o);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  vec_t burst[9] = '{
    '{3'd2, 16'hFF00, 16'h0F0F},
    '{3'd3, 16'hFF00, 16'h0F0F},
    '{3'd0, 16'h7FFF, 16'h0001},
    '{3'd1, 16'h0000, 16'h0000},
    '{3'd5, 16'h0001, 16'h000F},
    '{3'd6, 16'hFFFF, 16'hFFFF},
    '{3'd5, 16'hABCD, 16'h0010},
    '{3'd6, 16'h0100, 16'h0100},
    '{3'd1, 16'h0003, 16'h0003}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1; in_valid = 1'b1; op = 3'd0; rd_in = 3'd5;
    rs1_val = 16'd1; rs2_val = 16'd2; wb_ready = 1'b1;

    @(posedge clk); #1;
    check("reset_outs_0", {wb_valid, wb_we, wb_rd, wb_data, flag_z, flag_c, illegal_op, busy}, 32'd0);
    tick(1);
    check("reset_outs_1", {wb_valid, wb_we, wb_rd, wb_data, flag_z, flag_c, illegal_op, busy}, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    #2;
    check("in_ready_after_reset", {in_ready, busy, wb_valid}, 3'b100);
    @(posedge clk); #1;

    issue(3'd0, 3'd3, 16'hFFFF, 16'h0001);
    idle();
    check("add_bundle", {wb_valid, wb_we, wb_rd, wb_data, flag_z, flag_c},
          {1'b1, 1'b1, 3'd3, 16'h0000, 1'b1, 1'b1});
    tick(1);
    check("add_retired", wb_valid, 1'b0);

    issue(3'd1, 3'd1, 16'd5, 16'd7);
    check("sub_result", {wb_valid, wb_data, flag_c}, {1'b1, 16'hFFFE, 1'b1});
    issue(3'd5, 3'd2, 16'h0003, 16'd4);
    idle();
    check("shl_result", {wb_valid, wb_rd, wb_data, flag_c}, {1'b1, 3'd2, 16'h0030, 1'b0});
    tick(1);

    issue(3'd6, 3'd6, 16'd300, 16'd200);
    idle();
    for (int i = 0; i < 16; i++) begin
      check("mul_busy", {busy, in_ready, wb_valid}, 3'b100);
      tick(1);
    end
    check("mul_done", {wb_valid, wb_we, wb_rd, wb_data, flag_c}, {1'b1, 1'b1, 3'd6, 16'hEA60, 1'b0});
    tick(1);

    issue(3'd6, 3'd4, 16'd1234, 16'd5678);
    idle();
    tick(7);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    reset = 1'b0;
    check("abort_idle", {busy, wb_valid}, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wb_valid) seen = 1'b1;
      tick(1);
    end
    check("abort_no_wb", seen, 1'b0);
    issue(3'd0, 3'd1, 16'd2, 16'd2);
    idle();
    check("add_after_abort", {wb_valid, wb_data}, {1'b1, 16'd4});
    tick(1);

`ifdef EXEC_DIV_EN
    issue(3'd7, 3'd2, 16'd100, 16'd7);
    idle();
    for (int i = 0; i < 16; i++) begin
      check("div_busy", {busy, wb_valid}, 2'b10);
      tick(1);
    end
    check("div_result", {wb_valid, wb_we, wb_data}, {1'b1, 1'b1, 16'd14});
    tick(1);
    issue(3'd7, 3'd3, 16'd100, 16'd0);
    idle();
    tick(16);
    check("div_by_zero", {wb_valid, wb_we, wb_data}, {1'b1, 1'b1, 16'hFFFF});
    tick(1);
`else
    issue(3'd7, 3'd2, 16'd100, 16'd7);
    check("op7_illegal_a", {wb_valid, illegal_op, wb_we, wb_data, flag_z},
          {1'b1, 1'b1, 1'b0, 16'h0000, 1'b1});
    issue(3'd7, 3'd3, 16'd100, 16'd0);
    idle();
    check("op7_illegal_b", {wb_valid, illegal_op, wb_we, wb_rd}, {1'b1, 1'b1, 1'b0, 3'd3});
    tick(1);
`endif

    wb_ready = 1'b0;
    issue(3'd4, 3'd5, 16'h1234, 16'h00FF);
    idle();
    check("stall_first", {wb_valid, wb_data}, {1'b1, 16'h12CB});
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_hold", {wb_valid, wb_we, wb_rd, wb_data, in_ready},
            {1'b1, 1'b1, 3'd5, 16'h12CB, 1'b0});
    end
    wb_ready = 1'b1;
    tick(1);
    check("stall_release", wb_valid, 1'b0);

    for (int i = 0; i < 9; i++) issue(burst[i].o, R'(i), burst[i].a, burst[i].b);
    idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
